// File: rtl/rtl_kernel_wizard_0_example_wr_resp_tracker.sv
// Write-response tracker for the kernel AXI4 write master.
// Counts AW issues and B retirements, gates AW on credit, pulses done.
module rtl_kernel_wizard_0_example_wr_resp_tracker #(
  parameter  int C_NUM_WIDTH       = 32,
  parameter  int C_MAX_OUTSTANDING = 16,
  localparam int C_OUT_WIDTH       = $clog2(C_MAX_OUTSTANDING+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctrl_start,
  input  logic [C_NUM_WIDTH-1:0] num_txn,
  input  logic                   aw_hs,
  input  logic                   b_hs,
  input  logic [1:0]             bresp,
  output logic                   issue_allow,
  output logic [C_OUT_WIDTH-1:0] outstanding,
  output logic                   ctrl_done,
  output logic                   idle,
  output logic                   proto_err,
  output logic                   resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [C_OUT_WIDTH-1:0] MAX_OUT =
    C_OUT_WIDTH'(C_MAX_OUTSTANDING);
  localparam logic [C_NUM_WIDTH-1:0] ONE = C_NUM_WIDTH'(1);

  state_t                 state, state_n;
  logic [C_NUM_WIDTH-1:0] rem_issue, rem_issue_n;
  logic [C_NUM_WIDTH-1:0] rem_resp, rem_resp_n;
  logic [C_OUT_WIDTH-1:0] out_q, out_n;
  logic                   perr_q, perr_n;
  logic                   rerr_q, rerr_n;
  logic                   allow;
  logic                   aw_ok;
  logic                   b_ok;

  // Credit gate depends on registered state only
  assign allow = (state == S_RUN) &&
                 (rem_issue != '0) &&
                 (out_q < MAX_OUT);

  assign aw_ok = aw_hs && allow;
  assign b_ok  = b_hs && (state == S_RUN) &&
                 (out_q != '0);

  assign issue_allow = allow;
  assign outstanding = out_q;
  assign ctrl_done   = (state == S_DONE);
  assign idle        = (state == S_IDLE);
  assign proto_err   = perr_q;
  assign resp_err    = rerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rem_issue <= '0;
      rem_resp  <= '0;
      out_q     <= '0;
      perr_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state     <= state_n;
      rem_issue <= rem_issue_n;
      rem_resp  <= rem_resp_n;
      out_q     <= out_n;
      perr_q    <= perr_n;
      rerr_q    <= rerr_n;
    end
  end

  always_comb begin
    state_n     = state;
    rem_issue_n = rem_issue;
    rem_resp_n  = rem_resp;
    out_n       = out_q;
    perr_n      = perr_q;
    rerr_n      = rerr_q;
    unique case (state)
      S_IDLE: begin
        if (ctrl_start) begin
          rem_issue_n = num_txn;
          rem_resp_n  = num_txn;
          out_n       = '0;
          perr_n      = 1'b0;
          rerr_n      = 1'b0;
          state_n     = (num_txn == '0) ? S_DONE : S_RUN;
        end
        if (aw_hs || b_hs) begin
          perr_n = 1'b1;
        end
      end
      S_RUN: begin
        if (aw_hs && !aw_ok) begin
          perr_n = 1'b1;
        end
        if (b_hs && !b_ok) begin
          perr_n = 1'b1;
        end
        if (b_hs && (bresp != 2'b00)) begin
          rerr_n = 1'b1;
        end
        if (aw_ok) begin
          rem_issue_n = rem_issue - ONE;
        end
        if (b_ok) begin
          rem_resp_n = rem_resp - ONE;
        end
        unique case ({aw_ok, b_ok})
          2'b10:   out_n = out_q + 1'b1;
          2'b01:   out_n = out_q - 1'b1;
          default: out_n = out_q;
        endcase
        if (b_ok && (rem_resp == ONE)) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rtl_kernel_wizard_0_example_wr_resp_tracker.sv
// Scoreboard bench for the write-response tracker.
// Directed vectors queue expected outputs; a monitor checks per cycle.
module tb_rtl_kernel_wizard_0_example_wr_resp_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_start;
  logic [31:0] num_txn;
  logic        aw_hs;
  logic        b_hs;
  logic [1:0]  bresp;
  logic        issue_allow;
  logic [2:0]  outstanding;
  logic        ctrl_done;
  logic        idle;
  logic        proto_err;
  logic        resp_err;

  rtl_kernel_wizard_0_example_wr_resp_tracker #(
    .C_NUM_WIDTH(32),
    .C_MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctrl_start(ctrl_start),
    .num_txn(num_txn),
    .aw_hs(aw_hs),
    .b_hs(b_hs),
    .bresp(bresp),
    .issue_allow(issue_allow),
    .outstanding(outstanding),
    .ctrl_done(ctrl_done),
    .idle(idle),
    .proto_err(proto_err),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // {done, idle, issue_allow, proto_err, resp_err, outstanding[2:0]}
  wire [7:0] act = {ctrl_done, idle, issue_allow,
                    proto_err, resp_err, outstanding};

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        tag_q[$];
  bit [7:0]  val_q[$];
  string     nm_q[$];
  int        done_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tag_q.size() != 0 && tag_q[0] == cyc) begin
      int       t;
      bit [7:0] v;
      string    s;
      t = tag_q.pop_front();
      v = val_q.pop_front();
      s = nm_q.pop_front();
      n_tests++;
      if (act !== v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", s, t, act, v);
      end
    end
    if (ctrl_done === 1'b1) begin
      n_tests++;
      if (done_q.size() == 0 || done_q[0] != cyc) begin
        n_fail++;
        $display("FAIL done_pulse got=cyc%0d exp=%0s", cyc,
                 done_q.size() == 0 ? "none" : $sformatf("cyc%0d", done_q[0]));
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input bit [7:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", nm, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs; expectation is for the state after the edge
  task automatic step(input string nm, input logic s, input logic [31:0] n,
                      input logic a, input logic b, input logic [1:0] r,
                      input int eo, input logic eia, input logic ei,
                      input logic ed, input logic epe, input logic ere);
    ctrl_start = s;
    num_txn    = n;
    aw_hs      = a;
    b_hs       = b;
    bresp      = r;
    tag_q.push_back(cyc + 1);
    val_q.push_back({ed, ei, eia, epe, ere, 3'(eo)});
    nm_q.push_back(nm);
    if (ed) done_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    ctrl_start = 1'b0;
    num_txn    = '0;
    aw_hs      = 1'b0;
    b_hs       = 1'b0;
    bresp      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 8'b0100_0000);
    rst_n = 1'b1;

    // basic run, reaches the credit limit of 4
    step("b_start", 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("b_aw1",   0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step("b_aw2",   0, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    step("b_aw3",   0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step("b_aw4",   0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    step("b_b1",    0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    step("b_b2",    0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    step("b_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("b_b4",    0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("b_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // credit limit: 6 txns through 4 credits
    step("c_start", 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("c_aw1",   0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step("c_aw2",   0, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    step("c_aw3",   0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step("c_aw4",   0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    step("c_b1",    0, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    step("c_aw5",   0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    step("c_b2",    0, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    step("c_aw6",   0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    step("c_b3",    0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    step("c_b4",    0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    step("c_b5",    0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("c_b6",    0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("c_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // simultaneous aw and b at outstanding=1
    step("s_start", 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("s_aw1",   0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step("s_awb",   0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    step("s_aw3",   0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    step("s_b2",    0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("s_b3",    0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("s_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // zero-length run
    step("z_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("z_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // error flags
    step("e_start", 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("e_b0",    0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    step("e_aw1",   0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    step("e_bslv",  0, 0, 0, 1, 2, 0, 1, 0, 0, 1, 1);
    step("e_aw2",   0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
    step("e_b2",    0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
    step("e_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    step("e_idaw",  0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
    step("e_clr",   1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("e_aw",    0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step("e_awbad", 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    step("e_b",     0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    step("e_idle2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    // reset mid-run at outstanding=3
    step("r_start", 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("r_aw1",   0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step("r_aw2",   0, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    step("r_aw3",   0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step("r_hold",  0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 8'b0100_0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("r2_start", 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("r2_aw1",   0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    step("r2_aw2",   0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    step("r2_b1",    0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("r2_b2",    0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("r2_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (tag_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_drain got=%0d exp=0", tag_q.size());
    end
    n_tests++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_drain got=%0d exp=0", done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
